// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU and
// register-select codes, T-state encoding and control-word bit positions.
package control_sequencer_pkg;

  localparam int W = 16;
  localparam logic [2:0] PC_SEL = 3'd4;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP   = 4'd0;
  localparam opcode_t OP_ADD   = 4'd1;
  localparam opcode_t OP_SUB   = 4'd2;
  localparam opcode_t OP_AND   = 4'd3;
  localparam opcode_t OP_OR    = 4'd4;
  localparam opcode_t OP_NOT   = 4'd5;
  localparam opcode_t OP_INC   = 4'd6;
  localparam opcode_t OP_PASSY = 4'd7;
  localparam opcode_t OP_LOAD  = 4'd8;
  localparam opcode_t OP_STORE = 4'd9;
  localparam opcode_t OP_MOV   = 4'd10;
  localparam opcode_t OP_HALT  = 4'd15;

  localparam logic [2:0] ALU_PASS  = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_NOT   = 3'd5;
  localparam logic [2:0] ALU_INC   = 3'd6;
  localparam logic [2:0] ALU_PASSY = 3'd7;

  localparam logic [2:0] SEL_RD_1 = 3'd0;
  localparam logic [2:0] SEL_RD_2 = 3'd1;
  localparam logic [2:0] SEL_RS_1 = 3'd2;
  localparam logic [2:0] SEL_RS_2 = 3'd3;
  localparam logic [2:0] SEL_PC   = PC_SEL;

  typedef enum logic [3:0] {
    ST_F0   = 4'd0,
    ST_F1   = 4'd1,
    ST_F2   = 4'd2,
    ST_F3   = 4'd3,
    ST_E0   = 4'd4,
    ST_E1   = 4'd5,
    ST_E2   = 4'd6,
    ST_HALT = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_MOV   = 3'd4,
    CLS_HALT  = 3'd5
  } op_class_e;

  localparam int CW_GPR_IN      = 0;
  localparam int CW_GPR_OUT     = 1;
  localparam int CW_IR_IN       = 2;
  localparam int CW_MAR_IN      = 3;
  localparam int CW_MDR_IN      = 4;
  localparam int CW_MDR_OUT     = 5;
  localparam int CW_RAM_RD      = 6;
  localparam int CW_RAM_WR      = 7;
  localparam int CW_Y_IN        = 8;
  localparam int CW_Y_OUT       = 9;
  localparam int CW_Y_OFFSET_IN = 10;
  localparam int CW_Y_SHL       = 11;
  localparam int CW_Y_SHR       = 12;
  localparam int CW_Z_IN        = 13;
  localparam int CW_Z_OUT       = 14;
  localparam int CW_ALU_LSB     = 15;
  localparam int CW_SEL_LSB     = 18;
  localparam int CW_W           = 21;

  function automatic op_class_e op_class(input opcode_t op);
    op_class_e cls;
    if (op >= OP_ADD && op <= OP_PASSY) begin
      cls = CLS_ALU;
    end else begin
      case (op)
        OP_LOAD:  cls = CLS_LOAD;
        OP_STORE: cls = CLS_STORE;
        OP_MOV:   cls = CLS_MOV;
        OP_HALT:  cls = CLS_HALT;
        default:  cls = CLS_NOP;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the single-bus datapath
// plus debug latch (slave).
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  opcode_t    opcode;
  logic       S;
  logic [1:0] shift;
  logic       bus_req;
  logic       bus_grant;
  logic       halted;
  logic [3:0] tstate;
  logic [2:0] ALU_control;
  logic [2:0] GPR_select;
  logic       GPR_in;
  logic       GPR_out;
  logic       IR_in;
  logic       MAR_in;
  logic       MDR_in;
  logic       MDR_out;
  logic       RAM_enable_read;
  logic       RAM_enable_write;
  logic       Y_in;
  logic       Y_out;
  logic       Y_offset_in;
  logic       Y_shift_left;
  logic       Y_shift_right;
  logic       Z_in;
  logic       Z_out;

  modport master (
    input  opcode, S, shift, bus_req,
    output bus_grant, halted, tstate, ALU_control, GPR_select,
           GPR_in, GPR_out, IR_in, MAR_in, MDR_in, MDR_out,
           RAM_enable_read, RAM_enable_write,
           Y_in, Y_out, Y_offset_in, Y_shift_left, Y_shift_right, Z_in, Z_out
  );

  modport slave (
    output opcode, S, shift, bus_req,
    input  bus_grant, halted, tstate, ALU_control, GPR_select,
           GPR_in, GPR_out, IR_in, MAR_in, MDR_in, MDR_out,
           RAM_enable_read, RAM_enable_write,
           Y_in, Y_out, Y_offset_in, Y_shift_left, Y_shift_right, Z_in, Z_out
  );

endinterface

// File: rtl/control_sequencer_checker.sv
// Bus-integrity properties for the sequencer outputs: one bus driver at most,
// no GPR read/write collision, offset strobe never used.
module control_sequencer_checker (
  input logic one_shot_clock,
  input logic reset,
  input logic GPR_in,
  input logic GPR_out,
  input logic MDR_out,
  input logic Y_out,
  input logic Z_out,
  input logic Y_offset_in
);

  a_one_driver: assert property (@(posedge one_shot_clock) disable iff (reset)
    $onehot0({GPR_out, MDR_out, Y_out, Z_out}))
    else $error("bus driver clash");

  a_gpr_rw: assert property (@(posedge one_shot_clock) disable iff (reset)
    !(GPR_in && GPR_out))
    else $error("GPR_in and GPR_out together");

  a_no_offset: assert property (@(posedge one_shot_clock) disable iff (reset)
    !Y_offset_in)
    else $error("Y_offset_in raised");

endmodule

// File: rtl/control_sequencer_rom.sv
// Combinational control ROM: maps {T-state, opcode, S, shift} to the full
// datapath control word.
module control_sequencer_rom
  import control_sequencer_pkg::*;
(
  input  state_e          state,
  input  opcode_t         opcode,
  input  logic            S,
  input  logic [1:0]      shift,
  output logic [CW_W-1:0] cw
);

  logic      shift_any_s;
  op_class_e cls_s;

  assign shift_any_s = |shift;
  assign cls_s       = op_class(opcode);

  // Decode one micro-step into its strobes, ALU code and register select.
  always_comb begin
    cw = '0;
    case (state)
      ST_F0: begin
        cw[CW_GPR_OUT] = 1'b1;
        cw[CW_MAR_IN]  = 1'b1;
        cw[CW_Y_IN]    = 1'b1;
        cw[CW_SEL_LSB +: 3] = SEL_PC;
      end
      ST_F1: begin
        cw[CW_Z_IN]  = 1'b1;
        cw[CW_RAM_RD] = 1'b1;
        cw[CW_ALU_LSB +: 3] = ALU_INC;
      end
      ST_F2: begin
        cw[CW_Z_OUT]  = 1'b1;
        cw[CW_GPR_IN] = 1'b1;
        cw[CW_SEL_LSB +: 3] = SEL_PC;
      end
      ST_F3: begin
        cw[CW_MDR_OUT] = 1'b1;
        cw[CW_IR_IN]   = 1'b1;
      end
      ST_E0: begin
        case (cls_s)
          CLS_ALU: begin
            cw[CW_GPR_OUT] = 1'b1;
            cw[CW_Y_IN]    = 1'b1;
            cw[CW_SEL_LSB +: 3] = SEL_RS_2;
          end
          CLS_LOAD, CLS_STORE: begin
            cw[CW_GPR_OUT] = 1'b1;
            cw[CW_MAR_IN]  = 1'b1;
            cw[CW_SEL_LSB +: 3] = SEL_RS_1;
          end
          CLS_MOV: begin
            cw[CW_GPR_OUT] = 1'b1;
            cw[CW_Y_IN]    = 1'b1;
            cw[CW_SEL_LSB +: 3] = SEL_RS_1;
          end
          default: cw = '0;
        endcase
      end
      ST_E1: begin
        case (cls_s)
          CLS_ALU: begin
            // Y shifts while Rs_1 is on the bus so Z captures ALU(Rs_1, shifted Y).
            cw[CW_GPR_OUT] = 1'b1;
            cw[CW_Z_IN]    = 1'b1;
            cw[CW_Y_SHL]   = ~S & shift_any_s;
            cw[CW_Y_SHR]   = S & shift_any_s;
            cw[CW_SEL_LSB +: 3] = SEL_RS_1;
            cw[CW_ALU_LSB +: 3] = opcode[2:0];
          end
          CLS_LOAD: cw[CW_RAM_RD] = 1'b1;
          CLS_STORE: begin
            cw[CW_GPR_OUT] = 1'b1;
            cw[CW_MDR_IN]  = 1'b1;
            cw[CW_SEL_LSB +: 3] = SEL_RD_1;
          end
          CLS_MOV: begin
            cw[CW_Y_OUT]  = 1'b1;
            cw[CW_GPR_IN] = 1'b1;
            cw[CW_SEL_LSB +: 3] = SEL_RD_1;
          end
          default: cw = '0;
        endcase
      end
      ST_E2: begin
        case (cls_s)
          CLS_ALU: begin
            cw[CW_Z_OUT]  = 1'b1;
            cw[CW_GPR_IN] = 1'b1;
            cw[CW_SEL_LSB +: 3] = SEL_RD_1;
          end
          CLS_LOAD: begin
            cw[CW_MDR_OUT] = 1'b1;
            cw[CW_GPR_IN]  = 1'b1;
            cw[CW_SEL_LSB +: 3] = SEL_RD_1;
          end
          CLS_STORE: cw[CW_RAM_WR] = 1'b1;
          default:   cw = '0;
        endcase
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired micro-sequencer: fetch/execute T-state FSM with debug-latch bus
// arbitration that freezes the sequence while the bus is lent out.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                one_shot_clock,
  input  logic                reset,
  control_sequencer_if.master ctl
);

  state_e          state_r;
  state_e          state_next_s;
  state_e          step_s;
  logic            legal_s;
  opcode_t         opcode_r;
  logic            freeze_s;
  logic            grant_s;
  logic [CW_W-1:0] rom_cw_s;
  logic [CW_W-1:0] cw_s;

  assign freeze_s = ctl.bus_req;
  assign grant_s  = ctl.bus_req & ~reset;

  // State register and the opcode captured as the fetch completes.
  always_ff @(posedge one_shot_clock) begin
    if (reset) begin
      state_r  <= ST_F0;
      opcode_r <= OP_NOP;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_F3 && !freeze_s) begin
        opcode_r <= ctl.opcode;
      end else begin
        opcode_r <= opcode_r;
      end
    end
  end

  // Next-state: advance one micro-step unless frozen; unknown codes fall back to F0.
  always_comb begin
    step_s       = ST_F0;
    legal_s      = 1'b1;
    state_next_s = ST_F0;
    case (state_r)
      ST_F0: step_s = ST_F1;
      ST_F1: step_s = ST_F2;
      ST_F2: step_s = ST_F3;
      ST_F3: begin
        case (op_class(ctl.opcode))
          CLS_ALU, CLS_LOAD, CLS_STORE, CLS_MOV: step_s = ST_E0;
          CLS_HALT: step_s = ST_HALT;
          default:  step_s = ST_F0;
        endcase
      end
      ST_E0:   step_s = ST_E1;
      ST_E1:   step_s = (op_class(opcode_r) == CLS_MOV) ? ST_F0 : ST_E2;
      ST_E2:   step_s = ST_F0;
      ST_HALT: step_s = ST_HALT;
      default: begin
        step_s  = ST_F0;
        legal_s = 1'b0;
      end
    endcase
    state_next_s = (freeze_s && legal_s) ? state_r : step_s;
  end

  control_sequencer_rom u_rom (
    .state  (state_r),
    .opcode (opcode_r),
    .S      (ctl.S),
    .shift  (ctl.shift),
    .cw     (rom_cw_s)
  );

  // Output gating: reset and a granted bus silence every strobe.
  always_comb begin
    cw_s = '0;
    if (reset || freeze_s) begin
      cw_s = '0;
    end else begin
      cw_s = rom_cw_s;
    end
  end

  assign ctl.bus_grant        = grant_s;
  assign ctl.halted           = (state_r == ST_HALT);
  assign ctl.tstate           = state_r;
  assign ctl.ALU_control      = cw_s[CW_ALU_LSB +: 3];
  assign ctl.GPR_select       = cw_s[CW_SEL_LSB +: 3];
  assign ctl.GPR_in           = cw_s[CW_GPR_IN];
  assign ctl.GPR_out          = cw_s[CW_GPR_OUT];
  assign ctl.IR_in            = cw_s[CW_IR_IN];
  assign ctl.MAR_in           = cw_s[CW_MAR_IN];
  assign ctl.MDR_in           = cw_s[CW_MDR_IN];
  assign ctl.MDR_out          = cw_s[CW_MDR_OUT];
  assign ctl.RAM_enable_read  = cw_s[CW_RAM_RD];
  assign ctl.RAM_enable_write = cw_s[CW_RAM_WR];
  assign ctl.Y_in             = cw_s[CW_Y_IN];
  assign ctl.Y_out            = cw_s[CW_Y_OUT];
  assign ctl.Y_offset_in      = cw_s[CW_Y_OFFSET_IN];
  assign ctl.Y_shift_left     = cw_s[CW_Y_SHL];
  assign ctl.Y_shift_right    = cw_s[CW_Y_SHR];
  assign ctl.Z_in             = cw_s[CW_Z_IN];
  assign ctl.Z_out            = cw_s[CW_Z_OUT];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector table for the named scenarios, then random instruction
// streams with bus requests and resets checked against a step-list model.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam logic [14:0] M_GIN    = 15'h0001;
  localparam logic [14:0] M_GOUT   = 15'h0002;
  localparam logic [14:0] M_IRIN   = 15'h0004;
  localparam logic [14:0] M_MARIN  = 15'h0008;
  localparam logic [14:0] M_MDRIN  = 15'h0010;
  localparam logic [14:0] M_MDROUT = 15'h0020;
  localparam logic [14:0] M_RD     = 15'h0040;
  localparam logic [14:0] M_WR     = 15'h0080;
  localparam logic [14:0] M_YIN    = 15'h0100;
  localparam logic [14:0] M_YOUT   = 15'h0200;
  localparam logic [14:0] M_SHL    = 15'h0800;
  localparam logic [14:0] M_SHR    = 15'h1000;
  localparam logic [14:0] M_ZIN    = 15'h2000;
  localparam logic [14:0] M_ZOUT   = 15'h4000;
  localparam int HALT_POS = 15;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  op;
    logic        s;
    logic [1:0]  sh;
    logic        req;
    logic [26:0] exp;
  } vec_t;

  logic one_shot_clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  control_sequencer_if ctl ();

  control_sequencer dut (
    .one_shot_clock (one_shot_clock),
    .reset          (reset),
    .ctl            (ctl)
  );

  control_sequencer_checker chk (
    .one_shot_clock (one_shot_clock),
    .reset          (reset),
    .GPR_in         (ctl.GPR_in),
    .GPR_out        (ctl.GPR_out),
    .MDR_out        (ctl.MDR_out),
    .Y_out          (ctl.Y_out),
    .Z_out          (ctl.Z_out),
    .Y_offset_in    (ctl.Y_offset_in)
  );

  always #5 one_shot_clock = ~one_shot_clock;

  function automatic logic [26:0] mk(input logic g, input logic h, input logic [3:0] ts,
                                     input logic [2:0] alu, input logic [2:0] sel,
                                     input logic [14:0] m);
    return {g, h, ts, alu, sel, m};
  endfunction

  function automatic logic [26:0] actual();
    return {ctl.bus_grant, ctl.halted, ctl.tstate, ctl.ALU_control, ctl.GPR_select,
            ctl.Z_out, ctl.Z_in, ctl.Y_shift_right, ctl.Y_shift_left, ctl.Y_offset_in,
            ctl.Y_out, ctl.Y_in, ctl.RAM_enable_write, ctl.RAM_enable_read,
            ctl.MDR_out, ctl.MDR_in, ctl.MAR_in, ctl.IR_in, ctl.GPR_out, ctl.GPR_in};
  endfunction

  task automatic add(input string name, input logic rst, input logic [3:0] op, input logic s,
                     input logic [1:0] sh, input logic req, input logic [26:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.op = op; v.s = s; v.sh = sh; v.req = req; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [3:0] op, input logic s, input logic [1:0] sh);
    add("F0", 1'b0, op, s, sh, 1'b0, mk(1'b0, 1'b0, ST_F0, 3'd0, 3'd4, M_GOUT | M_MARIN | M_YIN));
    add("F1", 1'b0, op, s, sh, 1'b0, mk(1'b0, 1'b0, ST_F1, 3'd6, 3'd0, M_ZIN | M_RD));
    add("F2", 1'b0, op, s, sh, 1'b0, mk(1'b0, 1'b0, ST_F2, 3'd0, 3'd4, M_ZOUT | M_GIN));
    add("F3", 1'b0, op, s, sh, 1'b0, mk(1'b0, 1'b0, ST_F3, 3'd0, 3'd0, M_MDROUT | M_IRIN));
  endtask

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] op, input logic s,
                       input logic [1:0] sh, input logic req);
    reset = rst; ctl.opcode = op; ctl.S = s; ctl.shift = sh; ctl.bus_req = req;
  endtask

  // Each instruction is a fixed list of micro-steps: 4 fetch steps, then its execute list.
  function automatic int exec_len(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd9) return 3;
    if (op == 4'd10) return 2;
    return 0;
  endfunction

  // {alu, sel, strobes} of step 'pos' of the instruction 'op'.
  function automatic logic [20:0] micro(input int pos, input logic [3:0] op,
                                        input logic s, input logic [1:0] sh);
    logic [14:0] shm;
    shm = (sh == 2'd0) ? 15'd0 : (s ? M_SHR : M_SHL);
    if (pos == 0) return {3'd0, 3'd4, M_GOUT | M_MARIN | M_YIN};
    if (pos == 1) return {3'd6, 3'd0, M_ZIN | M_RD};
    if (pos == 2) return {3'd0, 3'd4, M_ZOUT | M_GIN};
    if (pos == 3) return {3'd0, 3'd0, M_MDROUT | M_IRIN};
    if (op >= 4'd1 && op <= 4'd7) begin
      if (pos == 4) return {3'd0, 3'd3, M_GOUT | M_YIN};
      if (pos == 5) return {op[2:0], 3'd2, M_GOUT | M_ZIN | shm};
      if (pos == 6) return {3'd0, 3'd0, M_ZOUT | M_GIN};
    end
    if (op == 4'd8) begin
      if (pos == 4) return {3'd0, 3'd2, M_GOUT | M_MARIN};
      if (pos == 5) return {3'd0, 3'd0, M_RD};
      if (pos == 6) return {3'd0, 3'd0, M_MDROUT | M_GIN};
    end
    if (op == 4'd9) begin
      if (pos == 4) return {3'd0, 3'd2, M_GOUT | M_MARIN};
      if (pos == 5) return {3'd0, 3'd0, M_GOUT | M_MDRIN};
      if (pos == 6) return {3'd0, 3'd0, M_WR};
    end
    if (op == 4'd10) begin
      if (pos == 4) return {3'd0, 3'd2, M_GOUT | M_YIN};
      if (pos == 5) return {3'd0, 3'd0, M_YOUT | M_GIN};
    end
    return 21'd0;
  endfunction

  function automatic logic [3:0] ts_of(input int pos);
    case (pos)
      0: return ST_F0;
      1: return ST_F1;
      2: return ST_F2;
      3: return ST_F3;
      4: return ST_E0;
      5: return ST_E1;
      6: return ST_E2;
      default: return ST_HALT;
    endcase
  endfunction

  initial begin
    int         pos;
    int         halt_cycles;
    logic [3:0] cur_op;
    logic [3:0] op_l;
    logic       rst;
    logic       req;
    logic       s;
    logic [1:0] sh;
    logic [20:0] m;

    // Directed table.
    add("reset_state", 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_F0, 3'd0, 3'd0, 15'd0));
    add_fetch(4'd0, 1'b0, 2'd0);
    add_fetch(4'd1, 1'b1, 2'd2);
    add("add_E0", 1'b0, 4'd1, 1'b1, 2'd2, 1'b0, mk(1'b0, 1'b0, ST_E0, 3'd0, 3'd3, M_GOUT | M_YIN));
    add("add_E1", 1'b0, 4'd1, 1'b1, 2'd2, 1'b0, mk(1'b0, 1'b0, ST_E1, 3'd1, 3'd2, M_GOUT | M_ZIN | M_SHR));
    add("add_E2", 1'b0, 4'd1, 1'b1, 2'd2, 1'b0, mk(1'b0, 1'b0, ST_E2, 3'd0, 3'd0, M_ZOUT | M_GIN));
    add_fetch(4'd9, 1'b0, 2'd0);
    add("st_E0", 1'b0, 4'd9, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E0, 3'd0, 3'd2, M_GOUT | M_MARIN));
    add("st_E1", 1'b0, 4'd9, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E1, 3'd0, 3'd0, M_GOUT | M_MDRIN));
    add("st_E2", 1'b0, 4'd9, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E2, 3'd0, 3'd0, M_WR));
    add_fetch(4'd8, 1'b0, 2'd0);
    add("ld_E0", 1'b0, 4'd8, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E0, 3'd0, 3'd2, M_GOUT | M_MARIN));
    add("ld_frz1", 1'b0, 4'd8, 1'b0, 2'd0, 1'b1, mk(1'b1, 1'b0, ST_E1, 3'd0, 3'd0, 15'd0));
    add("ld_frz2", 1'b0, 4'd8, 1'b0, 2'd0, 1'b1, mk(1'b1, 1'b0, ST_E1, 3'd0, 3'd0, 15'd0));
    add("ld_E1", 1'b0, 4'd8, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E1, 3'd0, 3'd0, M_RD));
    add("ld_E2", 1'b0, 4'd8, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E2, 3'd0, 3'd0, M_MDROUT | M_GIN));
    add_fetch(4'd9, 1'b0, 2'd0);
    add("st2_E0", 1'b0, 4'd9, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E0, 3'd0, 3'd2, M_GOUT | M_MARIN));
    add("st2_E1", 1'b0, 4'd9, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E1, 3'd0, 3'd0, M_GOUT | M_MDRIN));
    add("st2_rst", 1'b1, 4'd9, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_E2, 3'd0, 3'd0, 15'd0));
    add_fetch(4'd15, 1'b0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) add("halt_req", 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, mk(1'b1, 1'b1, ST_HALT, 3'd0, 3'd0, 15'd0));
      else        add("halt", 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b1, ST_HALT, 3'd0, 3'd0, 15'd0));
    end
    add("halt_rst", 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b1, ST_HALT, 3'd0, 3'd0, 15'd0));
    add("after_halt", 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, mk(1'b0, 1'b0, ST_F0, 3'd0, 3'd4, M_GOUT | M_MARIN | M_YIN));

    drive(1'b1, 4'd0, 1'b0, 2'd0, 1'b0);
    @(posedge one_shot_clock); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].s, vecs[i].sh, vecs[i].req);
      #4;
      check(vecs[i].name, actual(), vecs[i].exp);
      @(posedge one_shot_clock); #1;
    end

    // Random instruction stream against the step-list model.
    drive(1'b1, 4'd0, 1'b0, 2'd0, 1'b0);
    @(posedge one_shot_clock); #1;
    pos = 0; halt_cycles = 0; cur_op = 4'd0; op_l = 4'd0;
    for (int c = 0; c < 800; c++) begin
      if (pos == 0) begin
        cur_op = 4'($urandom_range(0, 15));
        if (cur_op == 4'd15 && $urandom_range(0, 3) != 0) cur_op = 4'd10;
      end
      rst = (halt_cycles >= 6) || ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 3) == 0);
      s   = 1'($urandom_range(0, 1));
      sh  = 2'($urandom_range(0, 3));
      drive(rst, cur_op, s, sh, req);
      m = (pos == HALT_POS || rst || req) ? 21'd0 : micro(pos, (pos < 4) ? cur_op : op_l, s, sh);
      #4;
      check("random", actual(), {(req & ~rst), (pos == HALT_POS), ts_of(pos), m});
      if (rst) begin
        pos = 0; halt_cycles = 0;
      end else if (pos == HALT_POS) begin
        halt_cycles++;
      end else if (!req) begin
        if (pos == 3) begin
          op_l = cur_op;
          pos = (cur_op == 4'd15) ? HALT_POS : ((exec_len(cur_op) > 0) ? 4 : 0);
        end else if (pos >= 4 && (pos - 3) >= exec_len(op_l)) begin
          pos = 0;
        end else begin
          pos++;
        end
      end
      @(posedge one_shot_clock); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
